// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: one shift-amount bit is resolved per register stage.
// Supports SLL/SRL/SRA/ROL with valid/ready handshakes and a global stall.
module shift_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam logic [1:0] ModeSll = 2'b00;
  localparam logic [1:0] ModeSrl = 2'b01;
  localparam logic [1:0] ModeSra = 2'b10;

  logic             adv;
  logic [SHW-1:0]   vld_q;
  logic [WIDTH-1:0] data_q [SHW];
  logic [1:0]       mode_q [SHW];
  logic [SHW-1:0]   amt_q  [SHW];

  logic [SHW-1:0]   vld_in;
  logic [WIDTH-1:0] data_in [SHW];
  logic [WIDTH-1:0] data_sh [SHW];
  logic [1:0]       mode_in [SHW];
  logic [SHW-1:0]   amt_in  [SHW];

  assign adv      = out_ready | ~vld_q[SHW-1];
  assign in_ready = adv;

  // Stage inputs: stage 0 takes the port, later stages take their predecessor.
  always_comb begin
    vld_in     = '0;
    vld_in[0]  = in_valid;
    data_in[0] = in_data;
    mode_in[0] = in_mode;
    amt_in[0]  = in_amt;
    for (int k = 1; k < SHW; k++) begin
      vld_in[k]  = vld_q[k-1];
      data_in[k] = data_q[k-1];
      mode_in[k] = mode_q[k-1];
      amt_in[k]  = amt_q[k-1];
    end
  end

  // Remaining amount bits are kept right-aligned, so bit 0 is always this stage's bit.
  always_comb begin
    for (int k = 0; k < SHW; k++) begin
      data_sh[k] = data_in[k];
      if (amt_in[k][0]) begin
        case (mode_in[k])
          ModeSll: data_sh[k] = data_in[k] << (1 << k);
          ModeSrl: data_sh[k] = data_in[k] >> (1 << k);
          ModeSra: data_sh[k] = WIDTH'($signed(data_in[k]) >>> (1 << k));
          default: data_sh[k] = (data_in[k] << (1 << k)) |
                                (data_in[k] >> (WIDTH - (1 << k)));
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < SHW; k++) begin
        data_q[k] <= '0;
        mode_q[k] <= '0;
        amt_q[k]  <= '0;
      end
    end else if (adv) begin
      vld_q <= vld_in;
      for (int k = 0; k < SHW; k++) begin
        data_q[k] <= data_sh[k];
        mode_q[k] <= mode_in[k];
        amt_q[k]  <= amt_in[k] >> 1;
      end
    end
  end

  assign out_valid = vld_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign out_zero  = ~|data_q[SHW-1];

  // The last stage's mode and leftover amount are state only, never consumed.
  logic unused_tail;
  assign unused_tail = ^{mode_q[SHW-1], amt_q[SHW-1]};

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: directed table vectors at WIDTH=8 plus random sweeps at 4/16/32,
// all checked through per-instance scoreboards with latency tracking.
module tb_shift_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] d;
    logic [2:0] a;
    logic [1:0] m;
    logic [7:0] e;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_shift(input int w, input logic [63:0] din, input int a,
                                            input logic [1:0] m);
    logic [63:0] mask, d, r;
    mask = (64'd1 << w) - 64'd1;
    d    = din & mask;
    case (m)
      2'b00: r = d << a;
      2'b01: r = d >> a;
      2'b10: begin
        r = d >> a;
        if (d[w-1]) r = r | (mask & ~(mask >> a));
      end
      default: r = (d << a) | (d >> (w - a));
    endcase
    return r & mask;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned W  = (g == 0) ? 8 : (g == 1) ? 4 : (g == 2) ? 16 : 32;
    localparam int unsigned SH = $clog2(W);

    logic          rst, in_valid, in_ready, out_valid, out_ready, out_zero;
    logic [W-1:0]  in_data, out_data, cur_exp;
    logic [SH-1:0] in_amt;
    logic [1:0]    in_mode;
    logic [63:0]   exp_q [$];
    int            acc_q [$];
    int            stl_q [$];
    int            stalls = 0;
    bit            done   = 1'b0;

    shift_pipe #(.WIDTH(W)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_amt   (in_amt),
      .in_mode  (in_mode),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_zero (out_zero)
    );

    // Scoreboard: push on accept, pop on delivery; stalls extend the expected latency.
    always @(negedge clk) begin
      logic [63:0] e;
      int a, s;
      if (rst) begin
        exp_q.delete();
        acc_q.delete();
        stl_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check($sformatf("w%0d_spurious_out", W), 64'(out_data), 64'hDEAD);
          end else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            s = stl_q.pop_front();
            check($sformatf("w%0d_data", W), 64'(out_data), e);
            check($sformatf("w%0d_zero", W), 64'(out_zero), 64'(e == 64'd0));
            check($sformatf("w%0d_latency", W), 64'(cyc - a - (stalls - s)), 64'(SH));
          end
        end
        if (out_valid && !out_ready) stalls++;
        if (in_valid && in_ready) begin
          exp_q.push_back(64'(cur_exp));
          acc_q.push_back(cyc);
          stl_q.push_back(stalls);
        end
      end
    end

    task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 200) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("w%0d_drained", W), 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
    endtask

    if (g == 0) begin : g_dir
      vec_t tbl [14];

      task automatic send(input int i);
        int n = 0;
        in_valid = 1'b1;
        in_data  = tbl[i].d;
        in_amt   = tbl[i].a;
        in_mode  = tbl[i].m;
        cur_exp  = tbl[i].e;
        do begin
          @(negedge clk);
          n++;
        end while (!in_ready && n < 50);
        check("accept", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
      endtask

      task automatic chk_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready"},  64'(in_ready),  64'd1);
        check({tag, "_out_data"},  64'(out_data),  64'd0);
        check({tag, "_out_zero"},  64'(out_zero),  64'd1);
      endtask

      initial begin
        tbl[0]  = '{8'hB3, 3'd3, 2'b00, 8'h98};
        tbl[1]  = '{8'h96, 3'd2, 2'b01, 8'h25};
        tbl[2]  = '{8'h96, 3'd2, 2'b10, 8'hE5};
        tbl[3]  = '{8'h96, 3'd3, 2'b11, 8'hB4};
        tbl[4]  = '{8'h96, 3'd0, 2'b00, 8'h96};
        tbl[5]  = '{8'h01, 3'd1, 2'b01, 8'h00};
        tbl[6]  = '{8'h80, 3'd7, 2'b10, 8'hFF};
        tbl[7]  = '{8'h81, 3'd7, 2'b11, 8'hC0};
        tbl[8]  = '{8'h7F, 3'd3, 2'b10, 8'h0F};
        tbl[9]  = '{8'hFF, 3'd7, 2'b00, 8'h80};
        tbl[10] = '{8'hFF, 3'd7, 2'b01, 8'h01};
        tbl[11] = '{8'hF0, 3'd4, 2'b01, 8'h0F};
        tbl[12] = '{8'h96, 3'd0, 2'b10, 8'h96};
        tbl[13] = '{8'h96, 3'd0, 2'b11, 8'h96};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0;
        out_ready = 1'b1; cur_exp = '0;
        #2 chk_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        send(0);
        drain();

        for (int i = 1; i <= 10; i++) send(i);
        send(12);
        send(13);
        drain();

        // Fill three beats, then hold the output while a fourth waits at the input.
        out_ready = 1'b0;
        send(3);
        send(6);
        send(9);
        in_valid = 1'b1;
        in_data  = tbl[11].d; in_amt = tbl[11].a; in_mode = tbl[11].m; cur_exp = tbl[11].e;
        repeat (4) begin
          @(negedge clk);
          check("bp_in_ready",  64'(in_ready),  64'd0);
          check("bp_out_valid", 64'(out_valid), 64'd1);
          check("bp_hold",      64'(out_data),  64'hB4);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        // Asynchronous reset between edges while a result is stalled at the output.
        out_ready = 1'b0;
        send(6);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        check("pre_rst_data",  64'(out_data),  64'hFF);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("async");
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) begin
          @(negedge clk);
          check("no_stale_a", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // Two beats in flight, reset one cycle later; nothing may emerge afterwards.
        send(1);
        send(2);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 chk_reset_outputs("midop");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) begin
          @(negedge clk);
          check("no_stale_b", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(0);
        drain();
        done = 1'b1;
      end
    end else begin : g_rnd
      initial begin
        bit hs;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0;
        out_ready = 1'b0; cur_exp = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          hs = in_valid && in_ready;
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
          // A pending beat is held until it is accepted.
          if (!in_valid || hs) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = W'($urandom);
            in_amt   = SH'($urandom);
            in_mode  = 2'($urandom);
            cur_exp  = W'(ref_shift(W, 64'(in_data), int'(in_amt), in_mode));
          end
        end
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();
        done = 1'b1;
      end
    end
  end

  initial begin
    int n = 0;
    while (!(g_dut[0].done && g_dut[1].done && g_dut[2].done && g_dut[3].done) && n < 20000)
    begin
      @(posedge clk);
      n++;
    end
    check("all_done", 64'({g_dut[0].done, g_dut[1].done, g_dut[2].done, g_dut[3].done}),
          64'hF);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Parametrised, pipelined barrel shifter: the next generation of our 8-bit left/right shifter, generalised to any power-of-two `WIDTH`. It supports four shift modes and has valid/ready handshakes on both sides. One shift-amount bit is resolved per pipeline stage, so full throughput is sustained at a fixed latency. It sits between a producer and a consumer in the ShiftRegArray datapath and replaces the combinational left/right pair wherever a registered, backpressure-aware shifter is needed.

## Interface
- `WIDTH`, 8, data width; power of two, ≥ 2.
- `SHW`, `$clog2(WIDTH)`, shift-amount width and pipeline depth (derived; not overridden).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block accepts the input beat this cycle.
- `in_data`  in  WIDTH  operand.
- `in_amt`  in  SHW  shift amount, 0 … WIDTH-1.
- `in_mode`  in  2  shift mode:
  - 00 SLL (logical left)
  - 01 SRL (logical right)
  - 10 SRA (arithmetic right)
  - 11 ROL (rotate left)
- `out_valid`  out  1  result beat valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  WIDTH  shifted result.
- `out_zero`  out  1  high when `out_data` == 0; qualified by `out_valid`.

## Operation
- Pipeline: SHW register stages, indexed 0 … SHW-1.
  - Stage k holds: valid bit, data, mode, and the amount bits not yet consumed.
  - Stage k shifts by 2^k when amount bit k is 1; otherwise it passes the data through.
  - Stage 0 takes `in_*`; stage SHW-1 drives `out_*`.
- Mode per stage, for a shift by s = 2^k:
  - SLL: `d << s`, zero fill.
  - SRL: `d >> s`, zero fill.
  - SRA: `d >> s`, filled with the MSB of that stage's input. Because each stage copies its own input MSB, the original sign bit propagates to every filled position.
  - ROL: `{d[WIDTH-1-s:0], d[WIDTH-1:WIDTH-s]}`.
- Result equals the single-step shift by `in_amt` in the selected mode. `in_amt` = 0 passes the operand through unchanged in every mode.
- Global advance: `adv = out_ready | ~out_valid`.
  - When `adv` is high, every stage loads from its predecessor, and stage 0 loads `in_*` with valid = `in_valid`.
  - When `adv` is low, every stage holds.
- `in_ready = adv`. This is combinational from `out_ready` and stage SHW-1 valid; it does not depend on `in_valid`.
- Bubbles are not compressed. An invalid stage advances like a valid one.
- `out_zero` is computed combinationally from the last stage's data register.
- Data and mode registers of invalid stages are don't-care. Valid bits are the only control state.

## Timing
- Reset (asynchronous, immediate on `rst` high, independent of `clk`):
  - All stage valid bits clear, so `out_valid`=0 and `in_ready`=1.
  - Data registers clear to 0, so `out_data`=0 and `out_zero`=1.
  - Mode and amount registers clear to 0.
- Reset mid-operation: every in-flight beat is discarded and none appears at the output after release. The first beat accepted after `rst` falls behaves exactly as after power-up.
- Latency: a beat accepted at edge N (`in_valid & in_ready`) presents `out_valid`=1 with its result after edge N+SHW-1, i.e. SHW cycles of register delay (3 cycles for WIDTH=8), provided no stall occurs.
- Throughput: one beat per cycle while `out_ready`=1.
- Stall: when `out_valid`=1 and `out_ready`=0:
  - `in_ready`=0 in the same cycle.
  - All stages and `out_*` hold their values stably until `out_ready` rises.
  - No beat is lost or duplicated.
- Output transfer: a beat transfers on an edge where `out_valid & out_ready`. On that same edge a new beat may enter stage 0 (simultaneous accept and deliver).
- `in_valid`=1 with `in_ready`=0: the beat is not accepted. The producer must hold it, and the block samples nothing.
- Beat order is preserved; there is no reordering across modes.

## Test plan
- Reset defaults: assert `rst` asynchronously between edges → `out_valid`=0, `in_ready`=1, `out_data`=0, `out_zero`=1 immediately. Deassert, then send SLL 8'hB3 amt 3 → 8'h98 exactly 3 cycles after accept.
- All modes, WIDTH=8, back-to-back beats with `out_ready`=1 (operand 8'h96, amt 2 unless stated):
  - SRL → 8'h25.
  - SRA → 8'hE5.
  - ROL amt 3 → 8'hB4.
  - SLL amt 0 → 8'h96.
  - Required: results appear on consecutive cycles, in input order.
- Zero flag: SRL 8'h01 amt 1 → `out_data`=8'h00, `out_zero`=1. SRA 8'h80 amt 7 → 8'hFF, `out_zero`=0.
- Backpressure: fill the pipeline with 3 beats, then hold `out_ready`=0 for 4 cycles → `in_ready`=0 and `out_data` held for all 4 cycles. Release → the 3 results drain in order, with no loss and no duplicates.
- Reset mid-operation: accept 2 beats, assert `rst` one cycle later → no stale result ever appears. The next accepted beat emerges with 3-cycle latency.
- Parameter sweep: WIDTH=4, 16, 32. Random operands, amounts and modes, with random `in_valid`/`out_ready` → every result matches a reference model. Latency equals SHW on unstalled beats.
